// File: rtl/cla_pipe.sv
// rtl/cla_pipe.sv - pipelined carry-lookahead adder/subtractor; status flags under CLA_PIPE_FLAGS_EN
module cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 8;
  localparam int L   = STAGES - 1;

  if (STAGES < 1 || STAGES > 4 || (WIDTH % (8 * STAGES)) != 0) begin : g_bad_cfg
    $error("cla_pipe: STAGES must be 1..4 and WIDTH a multiple of 8*STAGES");
  end

  // One segment: 8-bit groups, group carries as sum-of-products of the segment carry-in
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] g, p, c;
    logic [NG-1:0]  gg, gp;
    logic [NG:0]    ggx, gc;
    logic           t;
    g = x & y;
    p = x | y;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[8*j];
      gp[j] = p[8*j];
      for (int i = 1; i < 8; i++) begin
        gg[j] = g[8*j+i] | (p[8*j+i] & gg[j]);
        gp[j] = gp[j] & p[8*j+i];
      end
    end
    ggx = {gg, ci};
    for (int j = 0; j <= NG; j++) begin
      gc[j] = 1'b0;
      for (int m = 0; m <= j; m++) begin
        t = ggx[m];
        for (int n = m; n < j; n++) t = t & gp[n];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      c[8*j] = gc[j];
      for (int i = 1; i < 8; i++) c[8*j+i] = g[8*j+i-1] | (p[8*j+i-1] & c[8*j+i-1]);
    end
    return {gc[NG], x ^ y ^ c};
  endfunction

  logic             v_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             c_q   [STAGES];
  logic [STAGES:0]  rdy;
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic             src_c [STAGES];
  logic [SEG:0]     seg_r [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];

  // Ready chain: a stage can load when empty or when the stage after it can take its contents
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !v_q[k] || rdy[k+1];
  end

  // Each stage consumes the low SEG bits of its operands and shifts the finished slice into the sum
  always_comb begin
    src_v[0] = in_valid;
    src_s[0] = '0;
    src_a[0] = a;
    src_b[0] = b ^ {WIDTH{sub}};
    src_c[0] = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_s[k] = s_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_r[k] = seg_add(src_a[k][SEG-1:0], src_b[k][SEG-1:0], src_c[k]);
      s_d[k]   = (src_s[k] >> SEG) | (WIDTH'(seg_r[k][SEG-1:0]) << (WIDTH - SEG));
      a_d[k]   = src_a[k] >> SEG;
      b_d[k]   = src_b[k] >> SEG;
    end
  end

  // Pipeline registers: load when ready, hold otherwise; data only moves with a valid token
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            s_q[k] <= s_d[k];
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            c_q[k] <= seg_r[k][SEG];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign cout      = c_q[L];

`ifdef CLA_PIPE_FLAGS_EN
  logic z_q    [STAGES];
  logic am_q   [STAGES];
  logic bm_q   [STAGES];
  logic src_z  [STAGES];
  logic src_am [STAGES];
  logic src_bm [STAGES];
  logic ovf_q;

  // Flag sources: running all-zero product and operand sign bits travel with the data
  always_comb begin
    src_z[0]  = 1'b1;
    src_am[0] = a[WIDTH-1];
    src_bm[0] = src_b[0][WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      src_z[k]  = z_q[k-1];
      src_am[k] = am_q[k-1];
      src_bm[k] = bm_q[k-1];
    end
  end

  // Flag registers follow the same load/hold rule as the data path
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        z_q[k]  <= 1'b0;
        am_q[k] <= 1'b0;
        bm_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k] && src_v[k]) begin
          z_q[k]  <= src_z[k] && (seg_r[k][SEG-1:0] == '0);
          am_q[k] <= src_am[k];
          bm_q[k] <= src_bm[k];
        end
      end
      if (rdy[L] && src_v[L])
        ovf_q <= (src_am[L] == src_bm[L]) && (s_d[L][WIDTH-1] != src_am[L]);
    end
  end

  assign ovf  = ovf_q;
  assign zero = z_q[L];
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// tb/tb_cla_pipe.sv - directed bench for cla_pipe at STAGES 2, 1 and 4
module tb_cla_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;

  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [31:0] sum_w       [3];
  logic        cout_w      [3];
  logic        ovf_w       [3];
  logic        zero_w      [3];

  int total = 0;
  int passed = 0;

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vs [8];
  logic        vc [8];
  logic [31:0] es [8];
  logic        ec [8];
  logic        eo [8];
  logic        ez [8];

`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  always #5 clock = ~clock;

  cla_pipe #(.WIDTH(32), .STAGES(2)) dut_s2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0])
  );

  cla_pipe #(.WIDTH(32), .STAGES(1)) dut_s1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1])
  );

  cla_pipe #(.WIDTH(32), .STAGES(4)) dut_s4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2])
  );

  function automatic int stages_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic drive_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                          input logic icin);
    a = ia;
    b = ib;
    sub = isub;
    cin = icin;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    reset_n = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (out_valid_w[d] !== 1'b0) $display("FAIL reset_out_valid dut%0d got %b want 0", d, out_valid_w[d]);
      else passed++;
      total++;
      if (sum_w[d] !== 32'h0) $display("FAIL reset_sum dut%0d got %h want 0", d, sum_w[d]);
      else passed++;
      total++;
      if ({cout_w[d], ovf_w[d], zero_w[d]} !== 3'b000)
        $display("FAIL reset_flags dut%0d got %b want 000", d, {cout_w[d], ovf_w[d], zero_w[d]});
      else passed++;
    end
    reset_n = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (in_ready_w[d] !== 1'b1) $display("FAIL reset_in_ready dut%0d got %b want 1", d, in_ready_w[d]);
      else passed++;
    end
  endtask

  task automatic test_single_op(input int d, input string name, input logic [31:0] ia,
                                input logic [31:0] ib, input logic isub, input logic icin,
                                input logic [31:0] esum, input logic ecout, input logic eovf,
                                input logic ezero);
    int s;
    s = stages_of(d);
    do_reset();
    @(negedge clock);
    drive_op(ia, ib, isub, icin);
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    for (int i = 0; i < s; i++) begin
      @(negedge clock);
      total++;
      if (out_valid_w[d] !== (i == s - 1))
        $display("FAIL %s_latency dut%0d cycle %0d got %b want %b", name, d, i, out_valid_w[d], (i == s - 1));
      else passed++;
      if (i == s - 1) begin
        total++;
        if (sum_w[d] !== esum) $display("FAIL %s_sum dut%0d got %h want %h", name, d, sum_w[d], esum);
        else passed++;
        total++;
        if (cout_w[d] !== ecout) $display("FAIL %s_cout dut%0d got %b want %b", name, d, cout_w[d], ecout);
        else passed++;
        total++;
        if (ovf_w[d] !== (FLAGS & eovf)) $display("FAIL %s_ovf dut%0d got %b want %b", name, d, ovf_w[d], FLAGS & eovf);
        else passed++;
        total++;
        if (zero_w[d] !== (FLAGS & ezero)) $display("FAIL %s_zero dut%0d got %b want %b", name, d, zero_w[d], FLAGS & ezero);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back(input int d);
    int s;
    s = stages_of(d);
    do_reset();
    for (int n = 0; n <= s + 8; n++) begin
      @(negedge clock);
      total++;
      if (out_valid_w[d] !== (n >= s && n < s + 8))
        $display("FAIL b2b_valid dut%0d cycle %0d got %b want %b", d, n, out_valid_w[d], (n >= s && n < s + 8));
      else passed++;
      if (n >= s && n < s + 8) begin
        total++;
        if (sum_w[d] !== es[n-s] || cout_w[d] !== ec[n-s])
          $display("FAIL b2b_result dut%0d op %0d got %h/%b want %h/%b", d, n - s, sum_w[d], cout_w[d], es[n-s], ec[n-s]);
        else passed++;
        total++;
        if (ovf_w[d] !== (FLAGS & eo[n-s]) || zero_w[d] !== (FLAGS & ez[n-s]))
          $display("FAIL b2b_flags dut%0d op %0d got %b%b want %b%b", d, n - s, ovf_w[d], zero_w[d], FLAGS & eo[n-s], FLAGS & ez[n-s]);
        else passed++;
      end
      if (n < 8) begin
        total++;
        if (in_ready_w[d] !== 1'b1) $display("FAIL b2b_in_ready dut%0d cycle %0d got %b want 1", d, n, in_ready_w[d]);
        else passed++;
        drive_op(va[n], vb[n], vs[n], vc[n]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall(input int d);
    int s;
    int acc;
    logic take;
    s = stages_of(d);
    acc = 0;
    do_reset();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < s + 3; cyc++) begin
      @(negedge clock);
      drive_op(va[acc], vb[acc], vs[acc], vc[acc]);
      in_valid = 1'b1;
      take = in_ready_w[d];
      @(posedge clock);
      if (take) acc++;
    end
    @(negedge clock);
    total++;
    if (acc != s) $display("FAIL stall_accepts dut%0d got %0d want %0d", d, acc, s);
    else passed++;
    total++;
    if (in_ready_w[d] !== 1'b0) $display("FAIL stall_in_ready dut%0d got %b want 0", d, in_ready_w[d]);
    else passed++;
    repeat (3) @(negedge clock);
    total++;
    if (out_valid_w[d] !== 1'b1 || sum_w[d] !== es[0] || cout_w[d] !== ec[0])
      $display("FAIL stall_hold dut%0d got %b/%h/%b want 1/%h/%b", d, out_valid_w[d], sum_w[d], cout_w[d], es[0], ec[0]);
    else passed++;
    drive_op(va[s], vb[s], vs[s], vc[s]);
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready_w[d] !== 1'b1) $display("FAIL stall_pulse_ready dut%0d got %b want 1", d, in_ready_w[d]);
    else passed++;
    @(posedge clock);
    #1 out_ready = 1'b0;
    @(negedge clock);
    total++;
    if (out_valid_w[d] !== 1'b1 || sum_w[d] !== es[1])
      $display("FAIL stall_retire_one dut%0d got %b/%h want 1/%h", d, out_valid_w[d], sum_w[d], es[1]);
    else passed++;
    total++;
    if (in_ready_w[d] !== 1'b0) $display("FAIL stall_refull dut%0d got %b want 0", d, in_ready_w[d]);
    else passed++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < s; j++) begin
      total++;
      if (out_valid_w[d] !== 1'b1 || sum_w[d] !== es[1+j])
        $display("FAIL stall_drain dut%0d op %0d got %b/%h want 1/%h", d, 1 + j, out_valid_w[d], sum_w[d], es[1+j]);
      else passed++;
      @(negedge clock);
    end
    total++;
    if (out_valid_w[d] !== 1'b0) $display("FAIL stall_empty dut%0d got %b want 0", d, out_valid_w[d]);
    else passed++;
  endtask

  task automatic test_reset_midstream(input int d);
    int s;
    s = stages_of(d);
    do_reset();
    @(negedge clock);
    drive_op(va[1], vb[1], vs[1], vc[1]);
    in_valid = 1'b1;
    @(negedge clock);
    drive_op(va[2], vb[2], vs[2], vc[2]);
    @(posedge clock);
    #2 in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total++;
    if (out_valid_w[d] !== 1'b0 || sum_w[d] !== 32'h0 || cout_w[d] !== 1'b0)
      $display("FAIL midreset_clear dut%0d got %b/%h/%b want 0/0/0", d, out_valid_w[d], sum_w[d], cout_w[d]);
    else passed++;
    #3 reset_n = 1'b1;
    @(negedge clock);
    drive_op(32'd3, 32'd4, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    for (int i = 0; i < s + 2; i++) begin
      @(negedge clock);
      total++;
      if (out_valid_w[d] !== (i == s - 1))
        $display("FAIL midreset_valid dut%0d cycle %0d got %b want %b", d, i, out_valid_w[d], (i == s - 1));
      else passed++;
      if (i == s - 1) begin
        total++;
        if (sum_w[d] !== 32'd7) $display("FAIL midreset_sum dut%0d got %h want 7", d, sum_w[d]);
        else passed++;
      end
    end
  endtask

  initial begin
    va = '{32'h0000_0001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0000,
           32'h8000_0000, 32'h8000_0000, 32'h0000_FFFF, 32'hFFFF_FFFF};
    vb = '{32'h0000_0002, 32'h1111_1111, 32'h0000_0003, 32'h0000_0001,
           32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    es = '{32'h0000_0003, 32'h2345_678A, 32'h0000_000D, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h7FFF_FFFF, 32'h0001_0000, 32'h0000_0000};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    test_reset();
    for (int d = 0; d < 3; d++) begin
      test_single_op(d, "carry_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      test_single_op(d, "signed_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      test_single_op(d, "sub_borrow", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      test_back_to_back(d);
      test_stall(d);
    end
    test_reset_midstream(0);
    test_reset_midstream(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
